sram1rw_ctrl: RTL and testbench
===============================

// Module: sram1rw_ctrl
//
// PURPOSE
// Initiator side of the single-port SRAM macro pin interface (A/CSB/WEB/OEB/I/O).
// Converts a valid/ready request stream (read or write) into macro pin activity,
// absorbs the macro's one-cycle read latency, and returns read data on a
// valid/ready response stream through a small credit-protected response FIFO.
// Sits between a datapath client and one SRAM1RW macro. The macro's CE is clk.
//
// PARAMETERS
// ADDR_W     6  address width; must match macro depth (2**ADDR_W words)
// DATA_W     8  data word width; must match macro I/O width
// RSP_DEPTH  2  response FIFO entries; >=2 required for 1 read/cycle throughput
//
// PORTS
// clk        in   1       clock; also drives macro CE
// reset      in   1       synchronous, active-high reset
// req_valid  in   1       request present
// req_ready  out  1       request accepted when req_valid && req_ready (fire)
// req_write  in   1       1 = write, 0 = read
// req_addr   in   ADDR_W  word address
// req_wdata  in   DATA_W  write data (ignored for reads)
// rsp_valid  out  1       read data present
// rsp_ready  in   1       client takes response when rsp_valid && rsp_ready
// rsp_rdata  out  DATA_W  read data, in request order
// sram_A     out  ADDR_W  macro address
// sram_CSB   out  1       macro chip select, active low
// sram_WEB   out  1       macro write enable, active low (1 = read)
// sram_OEB   out  1       macro output enable, active low
// sram_I     out  DATA_W  macro write data
// sram_O     in   DATA_W  macro read data (tristate when OEB=1)
//
// BEHAVIOUR
// - Pin drive is combinational from the request: sram_CSB = ~fire;
//   sram_WEB = ~(fire && req_write); sram_A = req_addr; sram_I = req_wdata.
//   Macro samples at the clk edge ending the fire cycle N.
// - rd_pending (reg): set at end of N when a read fires, else cleared.
// - sram_OEB = ~rd_pending; sram_O sampled only when rd_pending=1, i.e. in N+1,
//   and pushed into the FIFO at end of N+1. rsp_valid earliest in N+2.
// - Writes: take effect at end of N; no response generated.
// - Credit: req_ready = !reset && (count + rd_pending - pop) < RSP_DEPTH, where
//   pop = rsp_valid && rsp_ready. req_ready never depends on req_valid/req_write.
//   Writes are gated by the same credit (simple, order-preserving).
// - FIFO: count 0..RSP_DEPTH; push and pop same cycle -> count unchanged; pointers
//   wrap modulo RSP_DEPTH (non-power-of-2 allowed). rsp_rdata = head entry,
//   held stable while rsp_valid && !rsp_ready.
// - Push into a full FIFO is impossible by credit; assert it never occurs.
// - Read after write to same address in consecutive cycles returns new data
//   (write completes at end of its own fire cycle).
// - Reset (sync): rd_pending=0, count=0, pointers=0; outputs during/after reset:
//   req_ready=0 while reset, rsp_valid=0, sram_CSB=1, sram_WEB=1, sram_OEB=1.
//   Reset mid-operation discards in-flight read and buffered responses; memory
//   contents are not cleared.
// - Throughput: with RSP_DEPTH>=2 and rsp_ready=1, one request per cycle,
//   read latency 2 cycles fire-to-rsp_valid.
//
// TESTING
// 1 Write 0xA5 @3, read @3, rsp_ready=1 -> rsp_valid 2 cycles after read fire,
//   rsp_rdata=0xA5; CSB low exactly in fire cycles, OEB low cycle after read.
// 2 Back-to-back reads @0..@63 after filling mem[i]=i, rsp_ready=1 -> req_ready
//   stays 1, 64 responses in order 0..63, one per cycle.
// 3 rsp_ready=0, issue reads -> exactly RSP_DEPTH(2) reads accepted, req_ready
//   drops to 0; raise rsp_ready -> responses drain in order, no loss/duplicate.
// 4 Write 0x3C @7 cycle N, read @7 cycle N+1 -> response 0x3C.
// 5 Assert reset the cycle after a read fires -> no rsp_valid ever for it;
//   sram_CSB/WEB/OEB=1 during reset; next read after reset returns prior data.
// 6 Random mixed traffic vs scoreboard model, random rsp_ready stalls -> all read
//   data matches, FIFO-overflow assertion never fires.

Source files
------------

// File: rtl/sram1rw_ctrl.sv
// Initiator for a single-port SRAM1RW macro: turns a valid/ready request stream
// into macro pin activity and returns read data through a credit-protected FIFO.
module sram1rw_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  // Handshakes: a transfer happens in the cycle where valid && ready are both 1.
  // req_ready never looks at req_valid/req_write; rsp_valid never looks at rsp_ready.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_A,
  output logic              sram_CSB,
  output logic              sram_WEB,
  output logic              sram_OEB,
  output logic [DATA_W-1:0] sram_I,
  input  logic [DATA_W-1:0] sram_O
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  logic              rd_pending_q, rd_pending_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] fifo_q [RSP_DEPTH];

  logic             fire;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occupancy;

  assign rsp_valid = !reset && (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = !reset && rd_pending_q;

  // Buffered responses plus the read still in the macro, minus what leaves now.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_pending_q}
                   - {{CNT_W{1'b0}}, pop};
  assign req_ready = !reset && (occupancy < DEPTH_C);
  assign fire      = req_valid && req_ready;

  assign sram_CSB  = ~fire;
  assign sram_WEB  = ~(fire && req_write);
  assign sram_A    = req_addr;
  assign sram_I    = req_wdata;
  assign sram_OEB  = ~push;
  assign rsp_rdata = fifo_q[rd_ptr_q];

  always_comb begin
    rd_pending_d = fire && !req_write;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending_q <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage carries no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= sram_O;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(rd_pending_q && count_q == FULL_C));

endmodule

// File: tb/tb_sram1rw_ctrl.sv
// Bench for sram1rw_ctrl: behavioural SRAM macro, queue-based response model,
// directed scenarios plus randomized traffic with response stalls.
module tb_sram1rw_ctrl;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [5:0] sram_A;
  logic       sram_CSB;
  logic       sram_WEB;
  logic       sram_OEB;
  logic [7:0] sram_I;
  logic [7:0] sram_O;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_count = 0;
  logic [7:0] last_rsp = '0;

  // Reference model: architectural memory plus expected in-order read data.
  logic [7:0] model_mem [64];
  logic [7:0] exp_q [$];

  // Behavioural macro: samples pins at the edge, read data appears next cycle.
  logic [7:0] sram_mem [64];
  logic [7:0] sram_dout;

  sram1rw_ctrl #(.ADDR_W(6), .DATA_W(8), .RSP_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_A(sram_A), .sram_CSB(sram_CSB), .sram_WEB(sram_WEB),
    .sram_OEB(sram_OEB), .sram_I(sram_I), .sram_O(sram_O)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // ---------------- macro model ----------------
  always @(posedge clk) begin
    if (!sram_CSB) begin
      if (!sram_WEB) sram_mem[sram_A] <= sram_I;
      else           sram_dout <= sram_mem[sram_A];
    end
  end
  assign sram_O = sram_OEB ? 8'hxx : sram_dout;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected_rsp: got rsp_rdata=%h, expected no response", rsp_rdata);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rsp_rdata !== e) begin
            n_errors++;
            $display("FAIL sb_rdata: got %h, expected %h", rsp_rdata, e);
          end
        end
        rsp_count++;
        last_rsp = rsp_rdata;
      end
      if (req_valid && req_ready) begin
        if (req_write) model_mem[req_addr] = req_wdata;
        else           exp_q.push_back(model_mem[req_addr]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds a request until it fires; returns one cycle after the fire edge.
  task automatic send(input logic w, input logic [5:0] a, input logic [7:0] d);
    bit done;
    done = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int t = 0; t < 100 && !done; t++) begin
      #1;
      if (req_ready) done = 1;
      next_cycle();
    end
    req_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL send_timeout: req_ready=%b, expected 1 within 100 cycles", req_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      #1;
      n_checks++;
      if ({req_ready, rsp_valid, sram_CSB, sram_WEB, sram_OEB} !== 5'b00111) begin
        n_errors++;
        $display("FAIL reset_outputs: ready,rsp_valid,CSB,WEB,OEB=%b, expected 00111",
                 {req_ready, rsp_valid, sram_CSB, sram_WEB, sram_OEB});
      end
      next_cycle();
    end
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || sram_OEB !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset: req_ready=%b rsp_valid=%b OEB=%b, expected 1 0 1",
               req_ready, rsp_valid, sram_OEB);
    end
    next_cycle();
  endtask

  task automatic test_basic();
    int base;
    base = rsp_count;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd3; req_wdata = 8'hA5;
    #1;
    n_checks++;
    if ({req_ready, sram_CSB, sram_WEB} !== 3'b100 || sram_A !== 6'd3 || sram_I !== 8'hA5) begin
      n_errors++;
      $display("FAIL basic_write_pins: ready,CSB,WEB=%b A=%0d I=%h, expected 100 3 a5",
               {req_ready, sram_CSB, sram_WEB}, sram_A, sram_I);
    end
    next_cycle();
    req_write = 1'b0; req_wdata = 8'h00;
    #1;
    n_checks++;
    if ({req_ready, sram_CSB, sram_WEB, sram_OEB} !== 4'b1011) begin
      n_errors++;
      $display("FAIL basic_read_pins: ready,CSB,WEB,OEB=%b, expected 1011",
               {req_ready, sram_CSB, sram_WEB, sram_OEB});
    end
    next_cycle();
    req_valid = 1'b0;
    #1;
    n_checks++;
    if ({sram_CSB, sram_OEB, rsp_valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL basic_n1: CSB,OEB,rsp_valid=%b, expected 100", {sram_CSB, sram_OEB, rsp_valid});
    end
    next_cycle();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || sram_OEB !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_n2: rsp_valid=%b rdata=%h OEB=%b, expected 1 a5 1",
               rsp_valid, rsp_rdata, sram_OEB);
    end
    next_cycle();
    n_checks++;
    if (rsp_count - base != 1 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_rsp_count: got %0d responses valid=%b, expected 1 0",
               rsp_count - base, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int t0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) send(1'b1, 6'(i), 8'(i));
    base = rsp_count;
    t0 = $time;
    for (int i = 0; i < 64; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 6'(i);
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_ready: read %0d req_ready=%b, expected 1", i, req_ready);
      end
      next_cycle();
    end
    req_valid = 1'b0;
    n_checks++;
    if (($time - t0) != 64 * 10) begin
      n_errors++;
      $display("FAIL b2b_cycles: issue took %0d ns, expected %0d", $time - t0, 640);
    end
    next_cycle();
    next_cycle();
    n_checks++;
    if (rsp_count - base != 64 || last_rsp !== 8'd63) begin
      n_errors++;
      $display("FAIL b2b_rsp: got %0d responses last=%0d, expected 64 63", rsp_count - base, last_rsp);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int base;
    acc = 0;
    base = rsp_count;
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 6'(10 + acc);
      #1;
      if (req_ready) acc++;
      next_cycle();
    end
    #1;
    n_checks++;
    if (acc != 2 || req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_accepted: accepted=%0d req_ready=%b, expected 2 0", acc, req_ready);
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'd10) begin
      n_errors++;
      $display("FAIL bp_hold: rsp_valid=%b rdata=%0d, expected 1 10", rsp_valid, rsp_rdata);
    end
    req_valid = 1'b0;
    next_cycle();
    rsp_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    n_checks++;
    if (rsp_count - base != 2 || last_rsp !== 8'd11 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain: got %0d responses last=%0d valid=%b, expected 2 11 0",
               rsp_count - base, last_rsp, rsp_valid);
    end
  endtask

  task automatic test_raw();
    rsp_ready = 1'b1;
    send(1'b1, 6'd7, 8'h3C);
    send(1'b0, 6'd7, 8'h00);
    next_cycle();
    next_cycle();
    n_checks++;
    if (last_rsp !== 8'h3C) begin
      n_errors++;
      $display("FAIL raw_data: got %h, expected 3c", last_rsp);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    rsp_ready = 1'b1;
    send(1'b1, 6'd20, 8'h77);
    base = rsp_count;
    send(1'b0, 6'd20, 8'h00);
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd20; req_wdata = 8'hEE;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if ({req_ready, rsp_valid, sram_CSB, sram_WEB, sram_OEB} !== 5'b00111) begin
        n_errors++;
        $display("FAIL midreset_outputs: ready,rsp_valid,CSB,WEB,OEB=%b, expected 00111",
                 {req_ready, rsp_valid, sram_CSB, sram_WEB, sram_OEB});
      end
      next_cycle();
    end
    req_valid = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) next_cycle();
    n_checks++;
    if (rsp_count != base) begin
      n_errors++;
      $display("FAIL midreset_discard: got %0d responses, expected 0", rsp_count - base);
    end
    send(1'b0, 6'd20, 8'h00);
    next_cycle();
    next_cycle();
    n_checks++;
    if (rsp_count - base != 1 || last_rsp !== 8'h77) begin
      n_errors++;
      $display("FAIL midreset_mem: got %0d responses data=%h, expected 1 77", rsp_count - base, last_rsp);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = 6'($urandom_range(0, 15));
      req_wdata = 8'($urandom_range(0, 255));
      rsp_ready = ($urandom_range(0, 2) != 0);
      next_cycle();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) next_cycle();
    n_checks++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL random_drain: %0d responses outstanding rsp_valid=%b, expected 0 0",
               exp_q.size(), rsp_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = 8'h00;
      sram_mem[i]  = 8'h00;
    end
    sram_dout = 8'h00;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    next_cycle();
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_raw();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
